pwm_capture: RTL

- Receive-side companion to the team's PWM generator: measures an incoming PWM waveform and recovers its high time, period and 4-bit quantised duty.
- Sits at the input pin boundary: asynchronous pwm_in is synchronised, edge-detected and timed in clk cycles.
- Each completed period is reported with a one-cycle valid strobe.
- Duty comes from a 4-iteration sequential divider, so duty = floor(16*high/period) and is directly comparable to the generator's 4-bit duty code.

---
 rtl/pwm_capture.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM input capture: synchronises pwm_in and measures high time and period in clk cycles.
// Reports a 4-bit duty code from a sequential restoring divider. Define
// PWM_CAPTURE_GLITCH_FILTER_EN to add a 3-sample glitch filter after the synchroniser.
module pwm_capture #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [3:0]       duty,
  output logic             valid,
  output logic             timeout,
  output logic             level
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW
  } state_e;

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   SUM_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   lvl;
  logic                   prev_q;
  logic                   rise;
  logic                   fall;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       hi_q, hi_d;
  logic [CNT_W-1:0]       lo_q, lo_d;
  logic [CNT_W:0]         sum;
  logic                   start;
  logic                   sat;

  logic [CNT_W-1:0]       rem_q;
  logic [CNT_W-1:0]       divp_q;
  logic [CNT_W-1:0]       hlat_q;
  logic [3:0]             quo_q;
  logic [2:0]             dcnt_q;
  logic                   done_q;
  logic                   busy;
  logic [CNT_W:0]         shl;
  logic [CNT_W:0]         diff;
  logic                   qbit;
  logic [CNT_W-1:0]       rem_next;

  logic [CNT_W-1:0]       high_q;
  logic [CNT_W-1:0]       period_q;
  logic [3:0]             duty_q;
  logic                   valid_q;
  logic                   timeout_q;
  logic                   level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // The level flips combinationally on the third agreeing sample, so the
  // filter costs exactly two cycles on each edge.
  always_comb begin
    lvl = filt_q;
    if (sync_s && hist_q[0] && hist_q[1]) begin
      lvl = 1'b1;
    end else if (!(sync_s || hist_q[0] || hist_q[1])) begin
      lvl = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_s};
      filt_q <= lvl;
    end
  end
`else
  assign lvl = sync_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= lvl;
    end
  end

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;
  assign sum  = {1'b0, hi_q} + {1'b0, lo_q};
  assign busy = (dcnt_q != 3'd0);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;
    sat     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_ARM;
      end
      S_ARM: begin
        if (rise) begin
          hi_d    = ONE;
          lo_d    = '0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (hi_q == '1) begin
          sat = 1'b1;
        end else if (fall) begin
          lo_d    = ONE;
          state_d = S_LOW;
        end else begin
          hi_d = hi_q + ONE;
        end
      end
      S_LOW: begin
        if (sum == SUM_MAX) begin
          sat = 1'b1;
        end else if (rise) begin
          start   = 1'b1;
          hi_d    = ONE;
          lo_d    = '0;
          state_d = S_HIGH;
        end else begin
          lo_d = lo_q + ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (sat) begin
      hi_d    = '0;
      lo_d    = '0;
      state_d = S_ARM;
    end
    if (!en) begin
      hi_d    = '0;
      lo_d    = '0;
      start   = 1'b0;
      sat     = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Borrow out of the trial subtraction decides the quotient bit.
  always_comb begin
    shl      = {rem_q, 1'b0};
    diff     = shl - {1'b0, divp_q};
    qbit     = ~diff[CNT_W];
    rem_next = qbit ? diff[CNT_W-1:0] : shl[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      divp_q <= '0;
      hlat_q <= '0;
      quo_q  <= '0;
      dcnt_q <= '0;
      done_q <= 1'b0;
    end else if (!en) begin
      dcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy) begin
        rem_q  <= hi_q;
        divp_q <= sum[CNT_W-1:0];
        hlat_q <= hi_q;
        quo_q  <= '0;
        dcnt_q <= 3'd4;
      end else if (busy) begin
        rem_q  <= rem_next;
        quo_q  <= {quo_q[2:0], qbit};
        dcnt_q <= dcnt_q - 3'd1;
        if (dcnt_q == 3'd1) done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_q    <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (done_q && en) begin
        valid_q   <= 1'b1;
        high_q    <= hlat_q;
        period_q  <= divp_q;
        duty_q    <= quo_q;
        timeout_q <= 1'b0;
      end
      if (sat) begin
        timeout_q <= 1'b1;
        level_q   <= lvl;
      end
    end
  end

  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign duty       = duty_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign level      = level_q;

endmodule
